// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation/state types and width constant for the multiply/divide unit
package mdu_pkg;
   localparam int MDU_WIDTH = 32;
   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } mdop_t;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_t;
endpackage

// File: rtl/mdu_absneg.sv
// mdu_absneg: conditional two's-complement negation, used for operand magnitudes and result sign fixup
module mdu_absneg
   import mdu_pkg::*;
#(
   parameter int W = MDU_WIDTH
) (
   input  logic [W-1:0] i_x,
   input  logic         i_neg,
   output logic [W-1:0] o_y
);
   assign o_y = i_neg ? (~i_x + W'(1)) : i_x;
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative radix-2 multiply/divide unit owning the HI/LO special registers
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNTW  = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mdop,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             spregwrite,
   input  logic             spaddr,
   input  logic             mf,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   mdu_state_t         r_state, w_state_nxt;
   mdop_t              w_op;
   logic               r_is_div, r_dz, r_neg_lo, r_neg_hi, r_done;
   logic [CNTW-1:0]    r_cnt;
   logic [WIDTH-1:0]   r_b, r_hi, r_lo;
   logic [2*WIDTH-1:0] r_acc;
   logic               w_signed, w_is_div, w_dz;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_fix_lo, w_fix_hi;
   logic [2*WIDTH-1:0] w_fix_prod, w_step;
   logic [WIDTH:0]     w_msum, w_dtrial;
   logic [2*WIDTH:0]   w_dshift;

   assign w_op     = mdop_t'(mdop);
   assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
   assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
   assign w_dz     = w_is_div && (srcb == '0);

   mdu_absneg #(.W(WIDTH)) u_abs_a (.i_x(srca), .i_neg(w_signed & srca[WIDTH-1]), .o_y(w_abs_a));
   mdu_absneg #(.W(WIDTH)) u_abs_b (.i_x(srcb), .i_neg(w_signed & srcb[WIDTH-1]), .o_y(w_abs_b));
   mdu_absneg #(.W(2*WIDTH)) u_fix_prod (.i_x(r_acc), .i_neg(r_neg_lo), .o_y(w_fix_prod));
   mdu_absneg #(.W(WIDTH)) u_fix_lo (.i_x(r_acc[WIDTH-1:0]), .i_neg(r_neg_lo & ~r_dz), .o_y(w_fix_lo));
   mdu_absneg #(.W(WIDTH)) u_fix_hi (.i_x(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_hi & ~r_dz), .o_y(w_fix_hi));

   // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right with carry.
   // Divide: acc = {remainder, dividend/quotient}; shift left, keep trial subtract if non-negative.
   assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_dshift = {r_acc, 1'b0};
   assign w_dtrial = w_dshift[2*WIDTH:WIDTH] - {1'b0, r_b};
   assign w_step   = !r_is_div ? {w_msum, r_acc[WIDTH-1:1]}
                   : w_dtrial[WIDTH] ? w_dshift[2*WIDTH-1:0]
                   : {w_dtrial[WIDTH-1:0], w_dshift[WIDTH-1:1], 1'b1};

   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign hi      = r_hi;
   assign lo      = r_lo;
   assign rd_data = mf ? (spaddr ? r_hi : r_lo) : '0;

   // State register
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else r_state <= w_state_nxt;

   // Next state: divide-by-zero skips the iteration, CALC exits after the last step
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == IDLE) ? (start ? (w_dz ? FIX : CALC) : IDLE)
                  : (r_state == CALC) ? ((r_cnt == CNTW'(1)) ? FIX : CALC)
                  : IDLE;
   end

   // Datapath: operand capture, iteration, HI/LO write-back and MT writes
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_dz     <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == FIX);
         if (r_state == IDLE && start) begin
            r_cnt    <= CNTW'(WIDTH);
            r_is_div <= w_is_div;
            r_dz     <= w_dz;
            r_neg_lo <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_neg_hi <= w_signed & srca[WIDTH-1];
            r_b      <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= w_dz ? {srca, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
         end else if (r_state == IDLE && spregwrite) begin
            if (spaddr) r_hi <= srca;
            else r_lo <= srca;
         end else if (r_state == CALC) begin
            r_cnt <= r_cnt - CNTW'(1);
            r_acc <= w_step;
         end else if (r_state == FIX) begin
            r_hi <= r_is_div ? w_fix_hi : w_fix_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_is_div ? w_fix_lo : w_fix_prod[WIDTH-1:0];
         end
      end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized self-checking bench for mdu_hilo against an arithmetic reference model
module tb_mdu_hilo;
   localparam int W = 32;
   logic         clk = 1'b0, reset = 1'b0, start = 1'b0, spregwrite = 1'b0, spaddr = 1'b0, mf = 1'b0;
   logic [1:0]   mdop = 2'b00;
   logic [W-1:0] srca = '0, srcb = '0;
   logic         busy, done;
   logic [W-1:0] rd_data, hi, lo;
   int           n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   mdu_hilo #(.WIDTH(W), .CNTW(6)) dut (
      .clk(clk), .reset(reset), .start(start), .mdop(mdop), .srca(srca), .srcb(srcb),
      .spregwrite(spregwrite), .spaddr(spaddr), .mf(mf),
      .busy(busy), .done(done), .rd_data(rd_data), .hi(hi), .lo(lo)
   );

   // The controller never issues start and an MT write together
   always @(posedge clk) assert (!(start && spregwrite)) else $error("controller issued start and spregwrite together");

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      if (op[1] && b == '0) return {a, 32'hFFFF_FFFF};
      case (op)
         2'd0:    r = sa * sb;
         2'd1:    r = ua * ub;
         2'd2:    r = {32'(sa % sb), 32'(sa / sb)};
         default: r = {32'(ua % ub), 32'(ua / ub)};
      endcase
      return r;
   endfunction

   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
      logic [63:0] exp;
      int dcyc, bcnt, exp_d;
      exp = model(op, a, b);
      exp_d = (op[1] && b == '0) ? 2 : W + 2;
      @(negedge clk);
      start = 1'b1; mdop = op; srca = a; srcb = b;
      @(posedge clk);
      #1 start = 1'b0; srca = $urandom; srcb = $urandom;
      dcyc = 0; bcnt = 0;
      for (int i = 1; i <= 40 && dcyc == 0; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) dcyc = i;
         if (poke && i == 5) begin
            spregwrite = 1'b1; spaddr = 1'b0; srca = 32'h0000_DEAD;
         end else spregwrite = 1'b0;
      end
      spregwrite = 1'b0;
      check({tag, "_done_cycle"}, 64'(dcyc), 64'(exp_d));
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_d - 1));
      check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
      @(negedge clk);
      check({tag, "_done_single"}, 64'(done), 64'd0);
   endtask

   task automatic mt(input logic addr, input logic [W-1:0] d);
      @(negedge clk);
      spregwrite = 1'b1; spaddr = addr; srca = d;
      @(negedge clk);
      spregwrite = 1'b0;
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max_hi_lit", 64'(hi), 64'hFFFF_FFFE);
      check("multu_max_lo_lit", 64'(lo), 64'h0000_0001);
      run_op("mult_neg", 2'd0, 32'hFFFF_FFF9, 32'd3, 1'b0);
      check("mult_neg_lo_lit", 64'(lo), 64'hFFFF_FFEB);
      run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg_lo_lit", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg_hi_lit", 64'(hi), 64'hFFFF_FFFF);
      run_op("divu", 2'd3, 32'd100, 32'd7, 1'b0);
      run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_lo_lit", 64'(lo), 64'h8000_0000);
      run_op("divu_zero", 2'd3, 32'd5, 32'd0, 1'b0);
      run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);

      mt(1'b0, 32'h0000_1234);
      @(negedge clk);
      mf = 1'b1; spaddr = 1'b0;
      #1 check("mflo", 64'(rd_data), 64'h1234);
      spaddr = 1'b1;
      #1 check("mfhi", 64'(rd_data), 64'hFFFF_FFF9);
      mf = 1'b0;
      #1 check("mf_off", 64'(rd_data), 64'd0);
      mt(1'b1, 32'h0000_CAFE);
      mf = 1'b1; spaddr = 1'b1;
      #1 check("mthi_mfhi", 64'(rd_data), 64'hCAFE);
      check("mthi_lo_kept", 64'(lo), 64'h1234);
      mf = 1'b0;

      run_op("mult_poke", 2'd0, 32'd12345, 32'hFFFF_FD4A, 1'b1);

      for (int k = 0; k < 24; k++) begin
         op = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
         run_op($sformatf("rnd%0d", k), op, a, b, 1'b0);
      end

      mt(1'b1, 32'h0000_AAAA);
      mt(1'b0, 32'h0000_5555);
      @(negedge clk);
      start = 1'b1; mdop = 2'd2; srca = 32'd1000; srcb = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_op("post_rst_multu", 2'd1, 32'd6, 32'd7, 1'b0);
      check("post_rst_lo_lit", 64'(lo), 64'd42);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with the architectural HI/LO special registers.
- Sits directly downstream of the controller and consumes its spregwrite, spaddr and mf decode, plus the register-file read operands srca and srcb.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles, asserting busy to stall the datapath.
- Serves MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- mdop  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srca  in  WIDTH  rs operand: multiplicand/dividend; MT source data
- srcb  in  WIDTH  rt operand: multiplier/divisor
- spregwrite  in  1  MTHI/MTLO write strobe
- spaddr  in  1  special register select: 0 LO, 1 HI (used by both write and read)
- mf  in  1  MFHI/MFLO read qualifier
- busy  out  1  operation in flight; datapath stalls on busy & (start | mf | spregwrite)
- done  out  1  one-cycle pulse in the cycle HI/LO are updated by an arithmetic op
- rd_data  out  WIDTH  spaddr ? hi : lo when mf = 1, else 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; hi, lo, accumulators and counter = 0; busy = 0; done = 0. Reset mid-operation aborts the operation with no HI/LO write.
- FSM states: IDLE, CALC, FIX.
- IDLE, start = 1:
  - Latch |srca| and |srcb| for signed ops; raw values for unsigned ops.
  - Record the result sign: MULT uses sign(a) ^ sign(b). DIV quotient uses sign(a) ^ sign(b); DIV remainder uses sign(a).
  - Load counter = WIDTH and go to CALC.
  - Exception: a divide with srcb = 0 goes straight to FIX with the div-by-zero flag set.
- CALC: one radix-2 step per cycle, counter decrements, leave to FIX when counter reaches 1→0.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIX: apply two's-complement negation per the recorded signs, then write hi/lo and pulse done; return to IDLE.
  - Multiply result: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide result: lo = quotient, hi = remainder.
  - Div-by-zero result: lo = all-ones, hi = srca as latched (unsigned raw / signed original value).
- Latency: start in cycle 0 → busy from cycle 1 through cycle WIDTH+1 → hi/lo and done valid in cycle WIDTH+2 (34 for WIDTH = 32). Div-by-zero results are valid in cycle 2.
- busy = (state != IDLE); it is registered and deasserts in the same cycle done pulses.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. This is the natural modulo-2^W result; no trap.
- MT write: spregwrite = 1 in IDLE with start = 0 writes srca to HI (spaddr = 1) or LO (spaddr = 0) at the next edge.
- Ignored inputs while busy = 1: spregwrite and start are ignored (the datapath holds them stalled).
- Simultaneous start and spregwrite in IDLE: start wins and the MT write is dropped. The controller never issues both; the bench checks this as an assertion.
- rd_data is combinational from registered hi/lo. While busy it reflects the old values; the stall ensures they are never consumed.
- Operands are sampled only at start; later changes on srca/srcb have no effect.

Decomposition:
- Package mdu_pkg:
  - mdop_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - mdu_state_t enum (IDLE, CALC, FIX)
  - localparam MDU_WIDTH = 32
- Sub-module mdu_absneg: combinational conditional two's-complement (neg ? -x : x). Used for operand magnitude and result fixup; instantiated per 32-bit path, with the product fixup handled at 2*WIDTH.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles: hi = 0xFFFFFFFE, lo = 0x00000001, one done pulse, busy high for exactly 33 cycles.
- MULT -7 (0xFFFFFFF9) × 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV -7 / 2 → lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIVU 100 / 7 → lo = 14, hi = 2.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5, done in cycle 2.
- MTLO 0x1234 then MFLO (mf = 1, spaddr = 0) → rd_data = 0x1234. During a MULT, spregwrite = 1 with 0xDEAD → lo unaffected, final product is correct.
- reset pulsed low at cycle 10 of a DIV → hi = lo = 0, busy = 0 immediately (asynchronously). A new MULTU 6 × 7 after release → lo = 42, hi = 0.
